divider_unit: RTL and testbench
===============================

Name: divider_unit

Overview:
- Iterative RV32M divide/remainder unit; it is the multi-cycle responder for the execute stage.
- The execute stage issues one request per valid/ready handshake. The unit returns one result through a second valid/ready handshake.
- It covers DIV, DIVU, REM and REMU, which the single-cycle ALU cannot do. It computes one restoring-division quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits; must equal $size(Data).

Ports:
- i_clock  input  1  single clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_valid  input  1  request valid from execute stage.
- o_ready  output 1  unit can accept a request.
- i_op  input  DivOp (2)  operation: DivOp_DIV, DivOp_DIVU, DivOp_REM, DivOp_REMU.
- i_dataA  input  WIDTH  dividend.
- i_dataB  input  WIDTH  divisor.
- o_valid  output 1  result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output WIDTH  quotient or remainder.

Behaviour:
- Reset: i_reset low forces state IDLE immediately, asynchronously.
  - Outputs while in reset: o_valid=0, o_ready=1, o_result=0.
  - All internal registers are cleared.
- States: IDLE, CALC, DONE. o_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE:
  - Accept occurs on an edge with i_valid & o_ready.
  - On accept, register op, sign flags and operand magnitudes. For DIVU/REMU, magnitudes are the raw values. For DIV/REM, magnitudes are the two's-complement absolute values.
  - Detect special cases at accept:
    - div-by-zero: i_dataB==0.
    - signed overflow: DIV/REM with i_dataA==0x80..0 and i_dataB all ones.
  - Clear the step counter, then go to CALC.
- CALC:
  - Each edge performs one restoring step via divider_step: remainder shifted left with the next dividend bit; trial subtract of the divisor; quotient bit = no borrow.
  - After WIDTH steps (counter reaches WIDTH-1), latch o_result and go to DONE.
- Latency: o_valid rises exactly WIDTH+1 edges after the accept edge (33 for WIDTH=32).
- Result fixup, applied when latching o_result:
  - DIV: quotient, negated if dividend sign ≠ divisor sign.
  - REM: remainder, negated if dividend was negative.
  - DIVU/REMU: raw quotient/remainder.
  - Div-by-zero overrides: quotient all ones (DIV and DIVU); remainder = original i_dataA.
  - Signed-overflow overrides: quotient 0x80..0; remainder 0.
- DONE:
  - o_result is held stable while o_valid is high.
  - On an edge with i_ready high, go to IDLE.
  - No new accept in the same cycle, since o_ready is low in DONE.
- Inputs are ignored outside the accept edge; operands need not stay stable after accept.
- Reset asserted mid-CALC or mid-DONE aborts the operation; no partial result is emitted.
- Counter is ceil(log2(WIDTH)) bits, with no wrap-around beyond WIDTH-1.

Optional Feature:
- Macro: DIVIDER_FAST_SPECIAL_EN.
- Defined: div-by-zero and signed-overflow requests skip CALC and go IDLE→DONE. o_valid rises 1 edge after accept, with the override result. Dividend 0 also takes the fast path, giving result 0.
- Undefined: every request takes the full WIDTH+1 latency. Overrides are applied at the CALC→DONE transition.
- Results are identical either way; only latency differs.

Decomposition:
- Package Types:
  - DivOp enum (DivOp_DIV, DivOp_DIVU, DivOp_REM, DivOp_REMU).
  - Existing Data type.
  - Helper constant DIV_STEP_BITS = $clog2($size(Data)).
- Sub-module divider_step: combinational single restoring iteration.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
- The FSM, counter and sign fixup stay in divider_unit.

Test Plan:
- DIVU 100/7 -> o_result 14, o_valid exactly 33 edges after accept; REMU 100/7 -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. Latency 1 edge with DIVIDER_FAST_SPECIAL_EN, 33 without.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: i_ready low for 5 cycles after o_valid -> o_result stable, o_ready low, second i_valid not accepted. i_ready high -> IDLE next edge, second request then accepted.
- Reset pulsed low at step 10 of a DIVU -> o_valid 0, o_ready 1 immediately. A following DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF.

Source files
------------

// File: rtl/divider_unit_pkg.sv
// Shared types for the RV32M divide/remainder unit.
// Holds the operation encoding, the data word type and the step-counter width.
// No logic beyond small decode helpers.
package divider_unit_pkg;

  typedef logic [31:0] Data;

  typedef enum logic [1:0] {
    DivOp_DIV  = 2'd0,
    DivOp_DIVU = 2'd1,
    DivOp_REM  = 2'd2,
    DivOp_REMU = 2'd3
  } DivOp;

  typedef enum logic [1:0] {
    DivState_IDLE = 2'd0,
    DivState_CALC = 2'd1,
    DivState_DONE = 2'd2
  } DivState;

  localparam int DIV_STEP_BITS = $clog2($bits(Data));

  function automatic logic op_is_signed(DivOp op);
    return (op == DivOp_DIV) || (op == DivOp_REM);
  endfunction

  function automatic logic op_is_rem(DivOp op);
    return (op == DivOp_REM) || (op == DivOp_REMU);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit,
  // and the trial difference one more for the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_diff_bit;

  // Trial subtract; a clear borrow means the quotient bit is 1 and the difference is kept.
  always_comb begin
    shifted         = {rem_in, next_bit};
    diff            = {1'b0, shifted} - {2'b00, divisor};
    quot_bit        = ~diff[WIDTH+1];
    rem_out         = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    // With no borrow the difference is below the divisor, so this bit is always zero.
    unused_diff_bit = diff[WIDTH];
  end

endmodule

// File: rtl/divider_unit.sv
// Iterative DIV/DIVU/REM/REMU unit, one restoring quotient bit per clock.
// Latency: o_valid on the WIDTH+1th edge counting the accept edge; 1 for specials with DIVIDER_FAST_SPECIAL_EN.
// Backpressure: o_ready only in IDLE; the result is held in DONE until i_ready is seen.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int WIDTH = $bits(Data)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  DivOp             i_op,
  input  logic [WIDTH-1:0] i_dataA,
  input  logic [WIDTH-1:0] i_dataB,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
);

  localparam int               CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  DivState          state;
  DivOp             op_q;
  logic             neg_quot, neg_rem, div_zero, ovf;
  logic [WIDTH-1:0] dvd, dvs, rem, quot, a_orig, result;
  logic [CW-1:0]    cnt;

  // Request decode, only meaningful on the accept edge.
  logic             in_signed, a_neg, b_neg, in_div_zero, in_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Magnitudes and special-case flags of the incoming request.
  always_comb begin
    in_signed   = op_is_signed(i_op);
    a_neg       = in_signed & i_dataA[WIDTH-1];
    b_neg       = in_signed & i_dataB[WIDTH-1];
    a_mag       = a_neg ? -i_dataA : i_dataA;
    b_mag       = b_neg ? -i_dataB : i_dataB;
    in_div_zero = (i_dataB == '0);
    in_ovf      = in_signed && (i_dataA == MIN_NEG) && (i_dataB == '1);
  end

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem),
    .divisor  (dvs),
    .next_bit (dvd[WIDTH-1]),
    .rem_out  (step_rem),
    .quot_bit (step_q)
  );

  // Sign correction and special-case overrides applied when the result is latched.
  function automatic logic [WIDTH-1:0] fixup(
    input DivOp             op,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r,
    input logic             nq,
    input logic             nr,
    input logic             dz,
    input logic             ov,
    input logic [WIDTH-1:0] a
  );
    logic is_rem;
    is_rem = op_is_rem(op);
    if (dz)          return is_rem ? a : '1;
    else if (ov)     return is_rem ? '0 : MIN_NEG;
    else if (is_rem) return nr ? -r : r;
    else             return nq ? -q : q;
  endfunction

  assign o_ready  = (state == DivState_IDLE);
  assign o_valid  = (state == DivState_DONE);
  assign o_result = result;

  // Control FSM with the shift/subtract datapath and result register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= DivState_IDLE;
      op_q     <= DivOp_DIV;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quot     <= '0;
      a_orig   <= '0;
      result   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        DivState_IDLE: begin
          if (i_valid) begin
            op_q     <= i_op;
            neg_quot <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= in_div_zero;
            ovf      <= in_ovf;
            dvd      <= a_mag;
            dvs      <= b_mag;
            rem      <= '0;
            quot     <= '0;
            a_orig   <= i_dataA;
            cnt      <= '0;
`ifdef DIVIDER_FAST_SPECIAL_EN
            // Specials and a zero dividend have known answers; skip the iteration.
            if (in_div_zero || in_ovf || (i_dataA == '0)) begin
              result <= fixup(i_op, '0, '0, 1'b0, 1'b0, in_div_zero, in_ovf, i_dataA);
              state  <= DivState_DONE;
            end else begin
              state  <= DivState_CALC;
            end
`else
            state    <= DivState_CALC;
`endif
          end
        end
        DivState_CALC: begin
          rem  <= step_rem;
          quot <= {quot[WIDTH-2:0], step_q};
          dvd  <= {dvd[WIDTH-2:0], 1'b0};
          if (cnt == LAST) begin
            result <= fixup(op_q, {quot[WIDTH-2:0], step_q}, step_rem,
                            neg_quot, neg_rem, div_zero, ovf, a_orig);
            state  <= DivState_DONE;
          end else begin
            cnt    <= cnt + CW'(1);
          end
        end
        DivState_DONE: begin
          if (i_ready) state <= DivState_IDLE;
        end
        default: state <= DivState_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: results and latency against a reference model.
// Expected results/latencies are queued at issue and compared when o_valid appears.
// Covers reset, unsigned/signed ops, specials, backpressure and reset abort.
module tb_divider_unit;
  import divider_unit_pkg::*;

  logic i_clock = 1'b0;
  logic i_reset, i_valid, i_ready, o_ready, o_valid;
  DivOp i_op;
  Data  i_dataA, i_dataB, o_result;

  int checks = 0;
  int errors = 0;
  Data exp_q[$];
  int  lat_q[$];

  divider_unit #(.WIDTH(32)) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_dataA  (i_dataA),
    .i_dataB  (i_dataB),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  always #5 i_clock = ~i_clock;

  function automatic Data ref_result(DivOp op, Data a, Data b);
    logic ov;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DivOp_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      DivOp_REMU: return (b == 0) ? a : a % b;
      DivOp_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : Data'($signed(a) / $signed(b));
      default:    return (b == 0) ? a : ov ? 32'h0 : Data'($signed(a) % $signed(b));
    endcase
  endfunction

  function automatic int ref_latency(DivOp op, Data a, Data b);
`ifdef DIVIDER_FAST_SPECIAL_EN
    logic sgn;
    sgn = (op == DivOp_DIV) || (op == DivOp_REM);
    if (b == 0 || a == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return (op == DivOp_DIV) ? 33 : 33;
  endfunction

  // Drive one request; returns #1 after the accept edge with operands scrambled.
  task automatic issue(input DivOp op, input Data a, input Data b, input bit track);
    if (track) begin
      exp_q.push_back(ref_result(op, a, b));
      lat_q.push_back(ref_latency(op, a, b));
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: o_ready=%b required 1", o_ready);
    end
    i_op = op; i_dataA = a; i_dataB = b; i_valid = 1'b1;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    i_dataA = $urandom; i_dataB = $urandom;
  endtask

  // Wait (bounded) for o_valid and compare result and latency with the queued expectation.
  task automatic collect(input string name);
    int  n;
    Data e;
    int  el;
    n = 1;
    while (!o_valid && n < 100) begin
      @(posedge i_clock); #1;
      n++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: o_valid=%b after %0d edges", name, o_valid, n);
    end else begin
      checks++;
      if (n !== el) begin
        errors++;
        $display("FAIL %s_latency: got %0d edges required %0d", name, n, el);
      end
      checks++;
      if (o_result !== e) begin
        errors++;
        $display("FAIL %s_result: got %h required %h", name, o_result, e);
      end
    end
  endtask

  // With i_ready high, the next edge must return the unit to IDLE.
  task automatic consume(input string name);
    @(posedge i_clock); #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: o_valid=%b o_ready=%b required 0/1", name, o_valid, o_ready);
    end
  endtask

  task automatic run(input DivOp op, input Data a, input Data b, input string name);
    issue(op, a, b, 1'b1);
    collect(name);
    consume(name);
  endtask

  task automatic test_reset;
    i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_op = DivOp_DIVU; i_dataA = '0; i_dataB = '0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: v=%b r=%b res=%h required 0/1/0", o_valid, o_ready, o_result);
    end
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b1;
  endtask

  task automatic test_unsigned;
    run(DivOp_DIVU, 32'd100, 32'd7, "divu_100_7");
    run(DivOp_REMU, 32'd100, 32'd7, "remu_100_7");
    run(DivOp_DIVU, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    run(DivOp_REMU, 32'd5, 32'd9, "remu_small");
  endtask

  task automatic test_signed;
    run(DivOp_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run(DivOp_REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run(DivOp_DIV, 32'd20, 32'hFFFF_FFFA, "div_20_m6");
    run(DivOp_REM, 32'd20, 32'hFFFF_FFFA, "rem_20_m6");
  endtask

  task automatic test_div_zero;
    run(DivOp_DIV,  32'd5, 32'd0, "div_5_0");
    run(DivOp_REM,  32'd5, 32'd0, "rem_5_0");
    run(DivOp_DIVU, 32'hFFFF_FFF0, 32'd0, "divu_x_0");
    run(DivOp_REM,  32'hFFFF_FFF0, 32'd0, "rem_neg_0");
    run(DivOp_DIV,  32'd0, 32'd3, "div_zero_dividend");
  endtask

  task automatic test_overflow;
    run(DivOp_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(DivOp_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      DivOp op;
      op = DivOp'($urandom_range(0, 3));
      run(op, $urandom, $urandom_range(1, 65535), "random");
    end
  endtask

  task automatic test_back_to_back;
    i_ready = 1'b0;
    issue(DivOp_DIVU, 32'd1000, 32'd3, 1'b1);
    collect("bp_first");
    exp_q.push_back(ref_result(DivOp_REMU, 32'd1000, 32'd3));
    lat_q.push_back(ref_latency(DivOp_REMU, 32'd1000, 32'd3));
    i_op = DivOp_REMU; i_dataA = 32'd1000; i_dataB = 32'd3; i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clock); #1;
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 32'd333) begin
        errors++;
        $display("FAIL bp_hold: cyc %0d v=%b r=%b res=%h required 1/0/0000014d", c, o_valid, o_ready, o_result);
      end
    end
    i_ready = 1'b1;
    @(posedge i_clock); #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: r=%b v=%b required 1/0", o_ready, o_valid);
    end
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: o_ready=%b required 0", o_ready);
    end
    collect("bp_second");
    consume("bp_second");
  endtask

  task automatic test_reset_abort;
    issue(DivOp_DIVU, 32'd12345, 32'd7, 1'b0);
    repeat (9) @(posedge i_clock);
    #1 i_reset = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset: v=%b r=%b res=%h required 0/1/0", o_valid, o_ready, o_result);
    end
    @(negedge i_clock) i_reset = 1'b1;
    @(posedge i_clock); #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: v=%b r=%b required 0/1", o_valid, o_ready);
    end
    run(DivOp_DIVU, 32'hFFFF_FFFF, 32'd16, "after_abort");
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_random;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
